// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand skew feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_N  = 2;
  localparam int DEF_DW = 8;

  // Counter must hold 0..2N-2 during FEED without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

  localparam int DEF_CNT_W = $clog2(2 * DEF_N);

  // Flat element index of matrix element (i,j), row-major.
  function automatic int idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/skew_lane_sel.sv
// Combinational selector for one skewed lane: picks element k-lane of a
// row/column vector when that offset lies inside the matrix, else zero.
module skew_lane_sel #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int CW = 2
) (
  input  logic [CW-1:0]   k,
  input  logic [CW-1:0]   lane,
  input  logic [N*DW-1:0] vec,
  output logic [DW-1:0]   data,
  output logic            vld
);

  logic [N-1:0] hit_s;

  // One-hot match of k == lane + m, then AND-OR mux of the hit element.
  always_comb begin
    hit_s = '0;
    data  = '0;
    for (int m = 0; m < N; m++) begin
      hit_s[m] = (k == (lane + CW'(m)));
      data     = data | ({DW{hit_s[m]}} & vec[m*DW +: DW]);
    end
    vld = |hit_s;
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand sequencer for an NxN output-stationary systolic array: captures
// A and B, clears accumulators, streams skewed lanes, drains, pulses done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              start,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic [N*DW-1:0]   a_lane,
  output logic [N-1:0]      a_vld,
  output logic [N*DW-1:0]   b_lane,
  output logic [N-1:0]      b_vld,
  output logic              acc_clr,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] K_LAST = CW'(2 * N - 2);
  localparam logic [CW-1:0] D_LAST = CW'(N - 2);

  state_t              state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic [N*N*DW-1:0]   a_r, b_r;
  logic [N-1:0][N*DW-1:0] b_col_s;
  logic [N-1:0][DW-1:0]   a_dat_s, b_dat_s;
  logic [N-1:0]        a_v_s, b_v_s;

  logic [N*DW-1:0]     a_lane_nxt_s, b_lane_nxt_s;
  logic [N-1:0]        a_vld_nxt_s, b_vld_nxt_s;
  logic                acc_clr_nxt_s, busy_nxt_s, done_nxt_s;

  // State and step counter register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state; counter restarts at 0 on entry to FEED and DRAIN.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = '0;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = LOAD;
        else       state_nxt_s = IDLE;
      end
      LOAD: state_nxt_s = FEED;
      FEED: begin
        if (cnt_r == K_LAST) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FEED;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_r == D_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture: only an accepted start loads new matrices.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_r <= '0;
      b_r <= '0;
    end else if (state_r == IDLE && start) begin
      a_r <= a_flat;
      b_r <= b_flat;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  // Gather each column of B into a contiguous vector, row index ascending.
  always_comb begin
    b_col_s = '0;
    for (int j = 0; j < N; j++) begin
      for (int m = 0; m < N; m++) begin
        b_col_s[j][m*DW +: DW] = b_r[idx(m, j, N)*DW +: DW];
      end
    end
  end

  // Lane selectors look ahead at the next step so outputs can be registered.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane_sel #(.N(N), .DW(DW), .CW(CW)) u_a_sel (
      .k    (cnt_nxt_s),
      .lane (CW'(i)),
      .vec  (a_r[i*N*DW +: N*DW]),
      .data (a_dat_s[i]),
      .vld  (a_v_s[i])
    );
    skew_lane_sel #(.N(N), .DW(DW), .CW(CW)) u_b_sel (
      .k    (cnt_nxt_s),
      .lane (CW'(i)),
      .vec  (b_col_s[i]),
      .data (b_dat_s[i]),
      .vld  (b_v_s[i])
    );
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    a_lane_nxt_s  = '0;
    b_lane_nxt_s  = '0;
    a_vld_nxt_s   = '0;
    b_vld_nxt_s   = '0;
    acc_clr_nxt_s = 1'b0;
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    case (state_nxt_s)
      LOAD: begin
        acc_clr_nxt_s = 1'b1;
        busy_nxt_s    = 1'b1;
      end
      FEED: begin
        busy_nxt_s   = 1'b1;
        a_lane_nxt_s = a_dat_s;
        b_lane_nxt_s = b_dat_s;
        a_vld_nxt_s  = a_v_s;
        b_vld_nxt_s  = b_v_s;
      end
      DRAIN:   busy_nxt_s = 1'b1;
      DONE:    done_nxt_s = 1'b1;
      IDLE:    busy_nxt_s = 1'b0;
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_lane  <= '0;
      b_lane  <= '0;
      a_vld   <= '0;
      b_vld   <= '0;
      acc_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a_lane  <= a_lane_nxt_s;
      b_lane  <= b_lane_nxt_s;
      a_vld   <= a_vld_nxt_s;
      b_vld   <= b_vld_nxt_s;
      acc_clr <= acc_clr_nxt_s;
      busy    <= busy_nxt_s;
      done    <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder (N=2 and N=3 instances).
module tb_systolic_skew_feeder;

  typedef struct packed {
    logic [31:0] stamp;
    logic        acc;
    logic        busy;
    logic        done;
    logic [2:0]  av;
    logic [2:0]  bv;
    logic [23:0] al;
    logic [23:0] bl;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start2, start3;
  logic [31:0] a2, b2;
  logic [71:0] a3, b3;

  logic [15:0] a_lane2, b_lane2;
  logic [1:0]  a_vld2, b_vld2;
  logic        acc2, busy2, done2;
  logic [23:0] a_lane3, b_lane3;
  logic [2:0]  a_vld3, b_vld3;
  logic        acc3, busy3, done3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base;
  rec_t q2[$];
  rec_t q3[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  systolic_skew_feeder #(.N(2), .DW(8)) dut2 (
    .wb_clk_i (clk), .wb_rst_n (rst_n), .start (start2),
    .a_flat (a2), .b_flat (b2),
    .a_lane (a_lane2), .a_vld (a_vld2), .b_lane (b_lane2), .b_vld (b_vld2),
    .acc_clr (acc2), .busy (busy2), .done (done2)
  );

  systolic_skew_feeder #(.N(3), .DW(8)) dut3 (
    .wb_clk_i (clk), .wb_rst_n (rst_n), .start (start3),
    .a_flat (a3), .b_flat (b3),
    .a_lane (a_lane3), .a_vld (a_vld3), .b_lane (b_lane3), .b_vld (b_vld3),
    .acc_clr (acc3), .busy (busy3), .done (done3)
  );

  task automatic push2(input int st, input logic acc, input logic bsy, input logic dn,
                       input logic [1:0] av, input logic [1:0] bv,
                       input logic [15:0] al, input logic [15:0] bl);
    rec_t r;
    r.stamp = st; r.acc = acc; r.busy = bsy; r.done = dn;
    r.av = {1'b0, av}; r.bv = {1'b0, bv}; r.al = {8'h00, al}; r.bl = {8'h00, bl};
    q2.push_back(r);
  endtask

  task automatic push3(input int st, input logic acc, input logic bsy, input logic dn,
                       input logic [2:0] av, input logic [2:0] bv,
                       input logic [23:0] al, input logic [23:0] bl);
    rec_t r;
    r.stamp = st; r.acc = acc; r.busy = bsy; r.done = dn;
    r.av = av; r.bv = bv; r.al = al; r.bl = bl;
    q3.push_back(r);
  endtask

  // Basic N=2 run with A=0x04030201, B=0x08070605; first cnt records pushed.
  task automatic exp_basic(input int b, input int cnt);
    if (cnt > 0) push2(b+1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
    if (cnt > 1) push2(b+2, 1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 16'h0001, 16'h0005);
    if (cnt > 2) push2(b+3, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 16'h0302, 16'h0607);
    if (cnt > 3) push2(b+4, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 16'h0400, 16'h0800);
    if (cnt > 4) push2(b+5, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
    if (cnt > 5) push2(b+6, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000);
  endtask

  task automatic chk_empty(input string name);
    tests++;
    if (q2.size() != 0 || q3.size() != 0) begin
      fails++;
      $display("FAIL %s: outstanding expected n2=%0d n3=%0d, required 0 and 0", name, q2.size(), q3.size());
    end
  endtask

  task automatic chk_zero2(input string name);
    tests++;
    if ({a_lane2, b_lane2, a_vld2, b_vld2, acc2, busy2, done2} != 39'd0) begin
      fails++;
      $display("FAIL %s: outputs al=%h bl=%h av=%b bv=%b acc=%b busy=%b done=%b, required all 0",
               name, a_lane2, b_lane2, a_vld2, b_vld2, acc2, busy2, done2);
    end
  endtask

  task automatic compare(input string name, input rec_t got, inout rec_t q[$]);
    rec_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected output at cyc=%0d: acc=%b busy=%b done=%b av=%b bv=%b al=%h bl=%h, required idle",
               name, got.stamp, got.acc, got.busy, got.done, got.av, got.bv, got.al, got.bl);
    end else begin
      e = q.pop_front();
      if (got != e) begin
        fails++;
        $display("FAIL %s: got cyc=%0d acc=%b busy=%b done=%b av=%b bv=%b al=%h bl=%h; required cyc=%0d acc=%b busy=%b done=%b av=%b bv=%b al=%h bl=%h",
                 name, got.stamp, got.acc, got.busy, got.done, got.av, got.bv, got.al, got.bl,
                 e.stamp, e.acc, e.busy, e.done, e.av, e.bv, e.al, e.bl);
      end
    end
  endtask

  // Monitor for the N=2 instance: any non-idle output pops one expectation.
  always @(negedge clk) begin
    rec_t g;
    if (acc2 | busy2 | done2 | (|a_vld2) | (|b_vld2) | (|a_lane2) | (|b_lane2)) begin
      g.stamp = cyc; g.acc = acc2; g.busy = busy2; g.done = done2;
      g.av = {1'b0, a_vld2}; g.bv = {1'b0, b_vld2};
      g.al = {8'h00, a_lane2}; g.bl = {8'h00, b_lane2};
      compare("n2_out", g, q2);
    end
  end

  // Monitor for the N=3 instance.
  always @(negedge clk) begin
    rec_t g;
    if (acc3 | busy3 | done3 | (|a_vld3) | (|b_vld3) | (|a_lane3) | (|b_lane3)) begin
      g.stamp = cyc; g.acc = acc3; g.busy = busy3; g.done = done3;
      g.av = a_vld3; g.bv = b_vld3; g.al = a_lane3; g.bl = b_lane3;
      compare("n3_out", g, q3);
    end
  end

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    a2 = 32'h04030201;
    b2 = 32'h08070605;
    a3 = 72'h090807060504030201;
    b3 = 72'h1211100F0E0D0C0B0A;

    // Reset state, then idle with start low.
    repeat (3) @(negedge clk);
    chk_zero2("reset_outputs");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_zero2("idle_after_reset");
    chk_empty("idle_no_activity");

    // Basic run.
    base = cyc;
    exp_basic(base, 6);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    chk_empty("basic_run");

    // Start during run plus operand change after capture.
    base = cyc;
    exp_basic(base, 6);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    a2 = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    start2 = 1'b0;
    repeat (12) @(negedge clk);
    a2 = 32'h04030201;
    chk_empty("busy_start_isolation");

    // Mid-run asynchronous reset.
    base = cyc;
    exp_basic(base, 2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero2("async_reset_mid_run");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_empty("mid_run_reset_no_done");

    // Fresh run after reset.
    base = cyc;
    exp_basic(base, 6);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    chk_empty("run_after_reset");

    // Back-to-back with start held for 20 cycles.
    base = cyc;
    exp_basic(base, 6);
    exp_basic(base + 7, 6);
    exp_basic(base + 14, 6);
    start2 = 1'b1;
    repeat (20) @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    chk_empty("back_to_back");

    // N=3 run, A=1..9, B=10..18.
    base = cyc;
    push3(base+1, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 24'h000000, 24'h000000);
    push3(base+2, 1'b0, 1'b1, 1'b0, 3'b001, 3'b001, 24'h000001, 24'h00000A);
    push3(base+3, 1'b0, 1'b1, 1'b0, 3'b011, 3'b011, 24'h000402, 24'h000B0D);
    push3(base+4, 1'b0, 1'b1, 1'b0, 3'b111, 3'b111, 24'h070503, 24'h0C0E10);
    push3(base+5, 1'b0, 1'b1, 1'b0, 3'b110, 3'b110, 24'h080600, 24'h0F1100);
    push3(base+6, 1'b0, 1'b1, 1'b0, 3'b100, 3'b100, 24'h090000, 24'h120000);
    push3(base+7, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 24'h000000, 24'h000000);
    push3(base+8, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 24'h000000, 24'h000000);
    push3(base+9, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 24'h000000, 24'h000000);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (14) @(negedge clk);
    chk_empty("n3_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Operand sequencer that sits directly upstream of the 2x2 (generalised NxN) output-stationary systolic array.
- Captures a full A and B operand matrix on a start pulse.
- Issues a clear to the PE accumulators.
- Streams A row-wise and B column-wise with the diagonal skew the array needs.
- Holds zeros while the array drains, then pulses done. This pulse is the array's start/done handshake toward the Wishbone wrapper.

Parameters:
N, 2, matrix dimension (legal 2..8).
DW, 8, operand width in bits (unsigned).

Ports:
wb_clk_i  input  1  single clock, rising edge.
wb_rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
a_flat  input  N*N*DW  matrix A, element (i,j) at bits [(i*N+j)*DW +: DW] (for N=2: A11 [7:0], A12 [15:8], A21 [23:16], A22 [31:24]).
b_flat  input  N*N*DW  matrix B, same layout.
a_lane  output  N*DW  row-lane operands, lane i at [i*DW +: DW].
a_vld  output  N  per-row-lane valid.
b_lane  output  N*DW  column-lane operands, lane j at [j*DW +: DW].
b_vld  output  N  per-column-lane valid.
acc_clr  output  1  one-cycle clear to all PE accumulators.
busy  output  1  high from LOAD through DRAIN.
done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_n is asynchronous and active-low.
- All outputs are registered. Reset value of every output is 0; state resets to IDLE and the counter to 0.
- FSM states: IDLE, LOAD, FEED, DRAIN, DONE.
- IDLE: start=1 latches a_flat and b_flat into internal operand registers and moves to LOAD. start=0 holds IDLE.
- LOAD: lasts 1 cycle. acc_clr=1, busy=1, all lanes 0 with valid 0. Then FEED with k=0.
- FEED: lasts 2N-1 cycles, k = 0..2N-2.
  - Row lane i: A[i][k-i] with a_vld[i]=1 when 0 <= k-i < N; otherwise data 0 and valid 0.
  - Column lane j: B[k-j][j] with b_vld[j]=1 under the same rule.
  - After k=2N-2, move to DRAIN.
- DRAIN: lasts N-1 cycles. All lanes 0, valids 0, busy=1.
- DONE: lasts 1 cycle. done=1 and busy=0 in the same cycle; then IDLE.
- Latency: for start sampled at edge t, acc_clr is high in cycle t+1, first valid data in cycle t+2, done in cycle t+3N. N=2 gives done at t+6.
- start while not in IDLE (including the DONE cycle) is ignored. No queuing.
- a_flat/b_flat changes after capture do not affect the current run.
- Reset asserted mid-run aborts immediately to IDLE with all outputs 0. done is not pulsed.
- Arithmetic: none on operands, which pass through unchanged. The counter is clog2(2N) bits and is cleared on entry to FEED and to DRAIN. The counter never wraps within a state.
- start held high continuously: a new run starts every 3N+1 cycles (IDLE, 1 cycle, then LOAD).

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE, LOAD, FEED, DRAIN, DONE).
  - default N and DW constants.
  - element-index function idx(i,j) = i*N+j.
  - counter-width constant.
- One natural sub-module: skew_lane_sel. It is combinational and, given k, a lane index and one matrix row/column, returns data and valid. It is instantiated N times for A and N times for B, and the results are registered in the parent.

Test Plan:
- Reset check: with N=2 and wb_rst_n=0, all outputs are 0. Release, hold start=0 for 10 cycles: outputs stay 0 and busy=0.
- Basic run, N=2, a_flat=0x04030201, b_flat=0x08070605, 1-cycle start at edge t:
  - cycle t+1: acc_clr=1.
  - cycle t+2: a_lane={0,1}, a_vld=01, b_lane={0,5}, b_vld=01.
  - cycle t+3: a_lane={3,2}, a_vld=11, b_lane={6,7}, b_vld=11.
  - cycle t+4: a_lane={4,0}, a_vld=10, b_lane={8,0}, b_vld=10.
  - cycle t+5: all lanes 0.
  - cycle t+6: done=1, busy=0.
- Busy-start and operand isolation: assert start again at t+3 and change a_flat to 0xFFFFFFFF. The stream is identical to the basic run, exactly one done pulse occurs, and no new run starts.
- Mid-run reset: pull wb_rst_n low at t+3. All outputs are 0 the same cycle (asynchronously), no done pulse, state IDLE. A fresh start after release gives the full basic-run sequence.
- Back-to-back: hold start=1 for 20 cycles. done pulses at t+6 and t+13, and acc_clr pulses at t+1 and t+8.
- N=3, DW=8, A=1..9, B=10..18 row-major: 5 feed cycles. Cycle k=2 gives a_lane={7,5,3} and b_lane={12,14,16}, all valid. done at t+9.
